// File: rtl/mf_clk_pkg.sv
// Shared definitions for the clock/reset supervision blocks.
// Supervisor states use fixed 2-bit codes so they read the same in every dump.
package mf_clk_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_state_e;

  localparam int unsigned REFCLK_HZ = 74_250_000;

endpackage

// File: rtl/mf_sync2.sv
// Generic two-flop single-bit synchroniser, cleared to 0 by synchronous reset.
module mf_sync2 (
  input  logic i_clk,
  input  logic i_srst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/mf_pll_supervisor.sv
// Core PLL bring-up supervisor: pulses the PLL reset, waits for lock with a timeout,
// debounces lock, then releases the core reset request; re-runs on lock loss.
module mf_pll_supervisor
  import mf_clk_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 742500,
  parameter int unsigned STABLE_CYCLES = 4096,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             i_refclk,
  input  logic             i_rst,
  input  logic             i_pll_locked,
  output logic             o_pll_rst,
  output logic             o_core_rst_req,
  output logic             o_ready,
  output logic             o_timeout_seen,
  output logic [CNT_W-1:0] o_lock_loss_cnt,
  output logic [CNT_W-1:0] o_retry_cnt
);

  localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);
  // The timer holds "cycles already spent in this state", so each limit is compared at N-1.
  localparam logic [TW-1:0]    RST_LAST = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0]    TO_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0]    STB_LAST = TW'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic            w_lk_s;
  pll_state_e      r_state;
  pll_state_e      w_state_next;
  logic [TW-1:0]   r_timer;
  logic [TW-1:0]   w_timer_next;
  logic            w_timeout_evt;
  logic            w_loss_evt;
  logic            r_pll_rst;
  logic            r_core_rst_req;
  logic            r_ready;
  logic            r_timeout_seen;
  logic [CNT_W-1:0] r_lock_loss_cnt;
  logic [CNT_W-1:0] r_retry_cnt;

  mf_sync2 u_lock_sync (
    .i_clk  (i_refclk),
    .i_srst (i_rst),
    .i_d    (i_pll_locked),
    .o_q    (w_lk_s)
  );

  always_comb begin
    w_state_next  = r_state;
    w_timeout_evt = 1'b0;
    w_loss_evt    = 1'b0;
    case (r_state)
      PLL_RST: begin
        if (r_timer == RST_LAST) w_state_next = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock is tested first so a lock on the final timeout cycle still wins.
        if (w_lk_s) begin
          w_state_next = STABLE;
        end else if (r_timer == TO_LAST) begin
          w_state_next  = PLL_RST;
          w_timeout_evt = 1'b1;
        end
      end
      STABLE: begin
        if (!w_lk_s)                  w_state_next = WAIT_LOCK;
        else if (r_timer == STB_LAST) w_state_next = RUN;
      end
      RUN: begin
        if (!w_lk_s) begin
          w_state_next = PLL_RST;
          w_loss_evt   = 1'b1;
        end
      end
      default: w_state_next = PLL_RST;
    endcase
    w_timer_next = ((w_state_next != r_state) || (r_state == RUN)) ? '0 : r_timer + 1'b1;
  end

  always_ff @(posedge i_refclk) begin
    if (i_rst) begin
      r_state         <= PLL_RST;
      r_timer         <= '0;
      r_pll_rst       <= 1'b1;
      r_core_rst_req  <= 1'b1;
      r_ready         <= 1'b0;
      r_timeout_seen  <= 1'b0;
      r_lock_loss_cnt <= '0;
      r_retry_cnt     <= '0;
    end else begin
      r_state        <= w_state_next;
      r_timer        <= w_timer_next;
      // Outputs follow the next state so they switch on the same edge as the FSM.
      r_pll_rst      <= (w_state_next == PLL_RST);
      r_core_rst_req <= (w_state_next != RUN);
      r_ready        <= (w_state_next == RUN);
      if (w_timeout_evt) begin
        r_timeout_seen <= 1'b1;
        if (r_retry_cnt != CNT_MAX) r_retry_cnt <= r_retry_cnt + 1'b1;
      end
      if (w_loss_evt && (r_lock_loss_cnt != CNT_MAX)) r_lock_loss_cnt <= r_lock_loss_cnt + 1'b1;
    end
  end

  assign o_pll_rst       = r_pll_rst;
  assign o_core_rst_req  = r_core_rst_req;
  assign o_ready         = r_ready;
  assign o_timeout_seen  = r_timeout_seen;
  assign o_lock_loss_cnt = r_lock_loss_cnt;
  assign o_retry_cnt     = r_retry_cnt;

endmodule
